mole_scorer: RTL and testbench

MOLE_SCORER -- requirements
Module: mole_scorer

---
 rtl/mole_pkg.sv | 29 ++
 rtl/mole_popcount.sv | 16 +
 rtl/mole_scorer.sv | 124 ++++++++++++
 tb/tb_mole_scorer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mole_pkg.sv
// Shared types, widths and defaults for the whack-a-mole scoring block.
package mole_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PLAY      = 2'd1,
      GAME_OVER = 2'd2
   } state_t;

   localparam int unsigned NUM_MOLES = 10;
   localparam int unsigned SCORE_W   = 16;
   localparam int unsigned CNT_W     = 8;
   localparam int unsigned COUNT_W   = 28;
   localparam int unsigned ROUND_W   = 5;
   localparam int unsigned POP_W     = 4;

   localparam int unsigned DEF_ROUND_TICKS = 50_000_000;
   localparam int unsigned DEF_QUICK_TICKS = 20_000_000;
   localparam int unsigned DEF_ROUNDS      = 30;

   // Event counter add that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_add_cnt(input logic [CNT_W-1:0] a,
                                                    input logic [POP_W-1:0] b);
      logic [CNT_W:0] s;
      s = (CNT_W+1)'(a) + (CNT_W+1)'(b);
      return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
   endfunction

endpackage

// File: rtl/mole_popcount.sv
// Combinational population count of a mole-wide vector.
module mole_popcount
   import mole_pkg::*;
(
   input  logic [NUM_MOLES-1:0] vec,
   output logic [POP_W-1:0]     cnt
);

   always_comb begin
      cnt = '0;
      for (int i = 0; i < NUM_MOLES; i++) begin
         cnt = cnt + POP_W'(vec[i]);
      end
   end

endmodule

// File: rtl/mole_scorer.sv
// Whack-a-mole scorer: hits, misses, escapes, rounds and saturating score.
// Optional build macro MOLE_MISS_PENALTY_EN makes each miss cost one point.
module mole_scorer
   import mole_pkg::*;
#(
   parameter int unsigned ROUND_TICKS = DEF_ROUND_TICKS,
   parameter int unsigned QUICK_TICKS = DEF_QUICK_TICKS,
   parameter int unsigned ROUNDS      = DEF_ROUNDS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [COUNT_W-1:0]   count,
   input  logic [NUM_MOLES-1:0] moles,
   input  logic [NUM_MOLES-1:0] switch,
   output logic [SCORE_W-1:0]   score,
   output logic [CNT_W-1:0]     hits,
   output logic [CNT_W-1:0]     misses,
   output logic [CNT_W-1:0]     escapes,
   output logic [ROUND_W-1:0]   round,
   output logic                 hit_pulse,
   output logic                 game_over
);

   localparam int unsigned SUM_W = SCORE_W + 2;
   localparam logic [SUM_W-1:0] SCORE_MAX = SUM_W'((2 ** SCORE_W) - 1);

   state_t                 state;
   logic [NUM_MOLES-1:0]   switch_q;
   logic [NUM_MOLES-1:0]   whacked;
   logic [NUM_MOLES-1:0]   toggle;
   logic [NUM_MOLES-1:0]   live;
   logic [NUM_MOLES-1:0]   hit_vec;
   logic [NUM_MOLES-1:0]   miss_vec;
   logic [NUM_MOLES-1:0]   esc_vec;
   logic [POP_W-1:0]       hit_cnt;
   logic [POP_W-1:0]       miss_cnt;
   logic [POP_W-1:0]       esc_cnt;
   logic                   boundary;
   logic                   quick;
   logic [ROUND_W-1:0]     round_nx;
   logic [SUM_W-1:0]       gain;
   logic [SCORE_W-1:0]     score_nx;

   mole_popcount u_pop_hit  (.vec(hit_vec),  .cnt(hit_cnt));
   mole_popcount u_pop_miss (.vec(miss_vec), .cnt(miss_cnt));
   mole_popcount u_pop_esc  (.vec(esc_vec),  .cnt(esc_cnt));

   // Per-cycle whack classification and next score.
   always_comb begin
      toggle   = switch ^ switch_q;
      live     = moles & ~whacked;
      hit_vec  = toggle & live;
      miss_vec = toggle & ~live;
      esc_vec  = live & ~hit_vec;
      boundary = (count == COUNT_W'(ROUND_TICKS));
      quick    = (count < COUNT_W'(QUICK_TICKS));
      round_nx = round + ROUND_W'(1);
      gain     = SUM_W'(score) + (quick ? (SUM_W'(hit_cnt) << 1) : SUM_W'(hit_cnt));
      score_nx = score;
`ifdef MOLE_MISS_PENALTY_EN
      if (gain < SUM_W'(miss_cnt)) begin
         score_nx = '0;
      end else if ((gain - SUM_W'(miss_cnt)) > SCORE_MAX) begin
         score_nx = {SCORE_W{1'b1}};
      end else begin
         score_nx = SCORE_W'(gain - SUM_W'(miss_cnt));
      end
`else
      score_nx = (gain > SCORE_MAX) ? {SCORE_W{1'b1}} : SCORE_W'(gain);
`endif
   end

   always_ff @(posedge clk) begin
      // Tracked in every state so that no stale toggle appears on entering PLAY.
      switch_q <= switch;
      if (!rst) begin
         state     <= IDLE;
         score     <= '0;
         hits      <= '0;
         misses    <= '0;
         escapes   <= '0;
         round     <= '0;
         whacked   <= '0;
         hit_pulse <= 1'b0;
         game_over <= 1'b0;
      end else begin
         hit_pulse <= 1'b0;
         case (state)
            IDLE, GAME_OVER: begin
               if (start) begin
                  state     <= PLAY;
                  score     <= '0;
                  hits      <= '0;
                  misses    <= '0;
                  escapes   <= '0;
                  round     <= '0;
                  whacked   <= '0;
                  game_over <= 1'b0;
               end
            end
            PLAY: begin
               hit_pulse <= |hit_vec;
               score     <= score_nx;
               hits      <= sat_add_cnt(hits, hit_cnt);
               misses    <= sat_add_cnt(misses, miss_cnt);
               if (boundary) begin
                  escapes <= sat_add_cnt(escapes, esc_cnt);
                  whacked <= '0;
                  round   <= round_nx;
                  if (round_nx == ROUND_W'(ROUNDS)) begin
                     state     <= GAME_OVER;
                     game_over <= 1'b1;
                  end
               end else begin
                  whacked <= whacked | hit_vec;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mole_scorer.sv
// Directed self-checking bench for mole_scorer with a two-round game.
module tb_mole_scorer;
   import mole_pkg::*;

   localparam int unsigned RT = DEF_ROUND_TICKS;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start;
   logic [COUNT_W-1:0]   count;
   logic [NUM_MOLES-1:0] moles;
   logic [NUM_MOLES-1:0] switch;
   logic [SCORE_W-1:0]   score;
   logic [CNT_W-1:0]     hits;
   logic [CNT_W-1:0]     misses;
   logic [CNT_W-1:0]     escapes;
   logic [ROUND_W-1:0]   round;
   logic                 hit_pulse;
   logic                 game_over;

   int checks = 0;
   int passed = 0;

   mole_scorer #(.ROUND_TICKS(RT), .QUICK_TICKS(DEF_QUICK_TICKS), .ROUNDS(2)) dut (
      .clk(clk), .rst(rst), .start(start), .count(count), .moles(moles),
      .switch(switch), .score(score), .hits(hits), .misses(misses),
      .escapes(escapes), .round(round), .hit_pulse(hit_pulse), .game_over(game_over)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic restart();
      rst = 1'b0;
      step();
      rst   = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      rst    = 1'b0;
      start  = 1'b0;
      count  = '0;
      moles  = '0;
      switch = '0;
      step();
      step();
      check("rst_score",     32'(score),     0);
      check("rst_hits",      32'(hits),      0);
      check("rst_misses",    32'(misses),    0);
      check("rst_escapes",   32'(escapes),   0);
      check("rst_round",     32'(round),     0);
      check("rst_pulse",     32'(hit_pulse), 0);
      check("rst_game_over", 32'(game_over), 0);

      // Quick single hit, then a second toggle on the already-whacked mole.
      restart();
      moles  = 10'h001;
      count  = 28'd1000;
      switch = switch ^ 10'h001;
      step();
      check("quick_score", 32'(score),     2);
      check("quick_hits",  32'(hits),      1);
      check("quick_pulse", 32'(hit_pulse), 1);
      step();
      check("pulse_drop",  32'(hit_pulse), 0);
      switch = switch ^ 10'h001;
      step();
      check("rehit_hits",   32'(hits),   1);
      check("rehit_misses", 32'(misses), 1);
`ifdef MOLE_MISS_PENALTY_EN
      check("rehit_score",  32'(score),  1);
`else
      check("rehit_score",  32'(score),  2);
`endif

      // Two slow simultaneous hits.
      restart();
      moles  = 10'h003;
      count  = 28'd30_000_000;
      switch = switch ^ 10'h003;
      step();
      check("dual_score",  32'(score),  2);
      check("dual_hits",   32'(hits),   2);
      check("dual_misses", 32'(misses), 0);

      // Two moles escape at a round boundary.
      restart();
      moles = 10'h300;
      count = COUNT_W'(RT);
      step();
      check("esc_escapes",   32'(escapes),   2);
      check("esc_round",     32'(round),     1);
      check("esc_game_over", 32'(game_over), 0);

      // Hit in the boundary cycle belongs to the outgoing round.
      restart();
      moles  = 10'h200;
      count  = COUNT_W'(RT);
      switch = switch ^ 10'h200;
      step();
      check("bnd_hits",    32'(hits),    1);
      check("bnd_escapes", 32'(escapes), 0);
      check("bnd_score",   32'(score),   1);

      // Whacked mask clears at boundary; game ends after two rounds.
      restart();
      moles  = 10'h001;
      count  = 28'd10;
      switch = switch ^ 10'h001;
      step();
      count = COUNT_W'(RT);
      step();
      check("clr_round",   32'(round),   1);
      check("clr_escapes", 32'(escapes), 0);
      count  = 28'd10;
      switch = switch ^ 10'h001;
      step();
      check("clr_hits",   32'(hits),   2);
      check("clr_misses", 32'(misses), 0);
      check("clr_score",  32'(score),  4);
      count = COUNT_W'(RT);
      step();
      check("go_flag",  32'(game_over), 1);
      check("go_round", 32'(round),     2);
      count  = 28'd10;
      switch = switch ^ 10'h001;
      step();
      check("go_score_frozen", 32'(score),     4);
      check("go_hits_frozen",  32'(hits),      2);
      check("go_pulse",        32'(hit_pulse), 0);
      check("go_hold",         32'(game_over), 1);
      start = 1'b1;
      step();
      start = 1'b0;
      check("new_score", 32'(score),     0);
      check("new_hits",  32'(hits),      0);
      check("new_round", 32'(round),     0);
      check("new_go",    32'(game_over), 0);
      switch = switch ^ 10'h001;
      step();
      check("new_hit", 32'(hits), 1);
      start = 1'b1;
      step();
      start = 1'b0;
      check("start_in_play", 32'(hits), 1);
      rst = 1'b0;
      step();
      rst = 1'b1;
      check("abort_hits",  32'(hits),  0);
      check("abort_score", 32'(score), 0);
      switch = switch ^ 10'h001;
      step();
      check("idle_ignore", 32'(hits), 0);

      // Miss counter saturates; score cannot go below zero.
      restart();
      moles = '0;
      count = 28'd10;
      for (int i = 0; i < 26; i++) begin
         switch = ~switch;
         step();
      end
      check("sat_misses", 32'(misses), 255);
      check("sat_hits",   32'(hits),   0);
      check("sat_score",  32'(score),  0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
